cu_state_decoder: RTL
=====================

Name: cu_state_decoder

Overview:
- Control-unit decoder for the simple CPU, on the consuming end of the sequence counter.
- Takes the counter state index and generates every register-transfer control strobe for the datapath.
- Drives load/inc/clr back into the sequence counter.
- Adds a memory-read handshake with wait states, an ack timeout, a sticky fault flag and a retired-instruction counter.

Parameters:
- N, 4, width of state index from the sequence counter
- TO_BITS, 4, width of the memory-wait timeout counter
- MEM_TIMEOUT, 12, wait cycles without mem_ack before fault; must be < 2**TO_BITS
- ICNT_BITS, 16, width of retired-instruction counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- state  in  N  current sequence counter value (FETCH1=0 … INC1=8)
- run  in  1  1 = execute; 0 = hold, no counter strobes issued
- mem_ack  in  1  memory read data valid this cycle
- mem_rd  out  1  memory read request
- ar_ld  out  1  load AR
- ar_sel  out  1  AR source: 0 = PC, 1 = DR[5:0]
- pc_ld  out  1  PC <- DR[5:0]
- pc_inc  out  1  PC <- PC+1
- dr_ld  out  1  DR <- memory data
- ir_ld  out  1  IR <- DR[7:6]
- ac_ld  out  1  AC <- ALU result
- ac_inc  out  1  AC <- AC+1
- alu_sel  out  1  0 = ADD, 1 = AND
- seq_load  out  1  to counter load
- seq_inc  out  1  to counter inc
- seq_clr  out  1  to counter clr
- fault  out  1  sticky fault flag
- instr_count  out  ICNT_BITS  retired-instruction count

Behaviour:
- All strobes are combinational from state, run, mem_ack and fault. Zero latency: the counter and datapath sample them on the same edge.
- All strobes are 0 when run=0 or fault=1.
- FETCH1 (0): ar_ld, ar_sel=0, seq_inc.
- FETCH2 (1): mem_rd=1. On the mem_ack cycle only: dr_ld, pc_inc, seq_inc.
- FETCH3 (2): ir_ld, ar_ld, ar_sel=1, seq_load.
- ADD1 (3) / AND1 (5): mem_rd=1. On mem_ack: dr_ld, seq_inc.
- ADD2 (4): ac_ld, alu_sel=0, seq_clr.
- AND2 (6): ac_ld, alu_sel=1, seq_clr.
- JMP1 (7): pc_ld, seq_clr.
- INC1 (8): ac_inc, seq_clr.
- mem_rd stays high every cycle in a memory state until mem_ack. mem_ack outside a memory state is ignored.
- At most one of seq_load/seq_inc/seq_clr is high in any cycle.
- Wait counter (registered):
  - Cleared on reset and on any cycle with mem_rd=0 or mem_ack=1.
  - Increments each cycle mem_rd=1 and mem_ack=0.
  - When it reaches MEM_TIMEOUT with mem_ack still 0: fault <= 1 next edge.
- Illegal state (9..15) while run=1: fault <= 1 next edge; seq_clr is not issued.
- fault is sticky, clears only on rst. While fault=1, mem_rd=0 and the wait counter holds 0.
- instr_count increments on every edge where seq_clr is issued (instruction retired).
  - Wraps modulo 2**ICNT_BITS.
  - Counts only while run=1 and fault=0.
- run dropping mid-wait: mem_rd drops and the wait counter clears. The read is reissued from count 0 when run returns.
- Reset mid-instruction: fault=0, instr_count=0, wait counter=0. Strobes follow the state input in the next cycle; the counter resets to FETCH1 in parallel.
- Reset values: fault=0, instr_count=0. Combinational outputs at state=0 with run=1 are those of FETCH1.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state index constants FETCH1..INC1
  - opcode constants OP_ADD/OP_AND/OP_JMP/OP_INC
  - a control-word struct bundling the datapath strobes
- The sequence counter's opcode mapping is refactored to use the same constants.
- One natural sub-module: mem_wait_timer (wait counter plus timeout compare, outputs timeout pulse).

Test Plan:
- ADD instruction, mem_ack same cycle as request: states 0→1→2→3→4→0. seq_clr in state 4 with ac_ld=1, alu_sel=0; instr_count 0→1.
- FETCH2 with mem_ack delayed 3 cycles: mem_rd high 4 cycles. dr_ld/pc_inc/seq_inc only in the 4th cycle; no strobes earlier.
- mem_ack withheld in ADD1: after 12 wait cycles fault=1, all strobes 0 thereafter. A late mem_ack is ignored; only rst clears fault.
- state=10 with run=1: fault=1 next cycle, seq_clr never asserted, instr_count unchanged.
- run=0 for 5 cycles in FETCH1, then run=1: no seq_inc during the hold; normal sequence resumes.
- rst in FETCH2 mid-wait with instr_count=7: next cycle instr_count=0, fault=0, wait counter 0; then JMP1 (state 7) gives pc_ld and seq_clr.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit definitions: sequence-counter state indices, opcodes,
// and the bundled datapath control word.
package cpu_ctrl_pkg;

   localparam int STATE_W = 4;

   localparam logic [3:0] FETCH1 = 4'd0;
   localparam logic [3:0] FETCH2 = 4'd1;
   localparam logic [3:0] FETCH3 = 4'd2;
   localparam logic [3:0] ADD1   = 4'd3;
   localparam logic [3:0] ADD2   = 4'd4;
   localparam logic [3:0] AND1   = 4'd5;
   localparam logic [3:0] AND2   = 4'd6;
   localparam logic [3:0] JMP1   = 4'd7;
   localparam logic [3:0] INC1   = 4'd8;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_AND = 2'b01;
   localparam logic [1:0] OP_JMP = 2'b10;
   localparam logic [1:0] OP_INC = 2'b11;

   typedef struct packed {
      logic mem_rd;
      logic ar_ld;
      logic ar_sel;
      logic pc_ld;
      logic pc_inc;
      logic dr_ld;
      logic ir_ld;
      logic ac_ld;
      logic ac_inc;
      logic alu_sel;
      logic seq_load;
      logic seq_inc;
      logic seq_clr;
   } ctrl_word_t;

   localparam ctrl_word_t CTRL_IDLE = '0;

   // Opcode to first execute state, used by the sequence counter's load path.
   function automatic logic [3:0] op_to_state(input logic [1:0] op);
      logic [3:0] r_s;
      case (op)
         OP_ADD:  r_s = ADD1;
         OP_AND:  r_s = AND1;
         OP_JMP:  r_s = JMP1;
         default: r_s = INC1;
      endcase
      return r_s;
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles a memory read waits for ack; pulses o_timeout
// when the count has reached MEM_TIMEOUT and the read is still waiting.
module mem_wait_timer #(
   parameter int TO_BITS     = 4,
   parameter int MEM_TIMEOUT = 12
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_wait,
   output logic               o_timeout,
   output logic [TO_BITS-1:0] o_count
);

   logic [TO_BITS-1:0] r_cnt;

   assign o_timeout = i_wait && (r_cnt == TO_BITS'(MEM_TIMEOUT));
   assign o_count   = r_cnt;

   // Clearing on the timeout edge leaves the counter at 0 once the fault is set.
   always_ff @(posedge clk) begin
      if (rst || !i_wait || o_timeout) begin
         r_cnt <= '0;
      end else if (r_cnt != '1) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/cu_state_decoder.sv
// Control-unit decoder: turns the sequence-counter state into datapath and
// counter strobes, with memory-wait timeout, sticky fault and retire count.
module cu_state_decoder
   import cpu_ctrl_pkg::*;
#(
   parameter int N           = 4,
   parameter int TO_BITS     = 4,
   parameter int MEM_TIMEOUT = 12,
   parameter int ICNT_BITS   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         state,
   input  logic                 run,
   input  logic                 mem_ack,
   output logic                 mem_rd,
   output logic                 ar_ld,
   output logic                 ar_sel,
   output logic                 pc_ld,
   output logic                 pc_inc,
   output logic                 dr_ld,
   output logic                 ir_ld,
   output logic                 ac_ld,
   output logic                 ac_inc,
   output logic                 alu_sel,
   output logic                 seq_load,
   output logic                 seq_inc,
   output logic                 seq_clr,
   output logic                 fault,
   output logic [ICNT_BITS-1:0] instr_count,
   output logic [TO_BITS-1:0]   wait_cnt
);

   ctrl_word_t             w_cw;
   logic                   w_illegal;
   logic                   w_wait;
   logic                   w_timeout;
   logic                   r_fault;
   logic [ICNT_BITS-1:0]   r_icnt;

   // Memory states hold mem_rd until ack; the ack cycle alone advances.
   always_comb begin
      w_cw      = CTRL_IDLE;
      w_illegal = 1'b0;
      if (run && !r_fault) begin
         case (state)
            N'(FETCH1): begin
               w_cw.ar_ld   = 1'b1;
               w_cw.seq_inc = 1'b1;
            end
            N'(FETCH2): begin
               w_cw.mem_rd = 1'b1;
               if (mem_ack) begin
                  w_cw.dr_ld   = 1'b1;
                  w_cw.pc_inc  = 1'b1;
                  w_cw.seq_inc = 1'b1;
               end
            end
            N'(FETCH3): begin
               w_cw.ir_ld    = 1'b1;
               w_cw.ar_ld    = 1'b1;
               w_cw.ar_sel   = 1'b1;
               w_cw.seq_load = 1'b1;
            end
            N'(ADD1), N'(AND1): begin
               w_cw.mem_rd = 1'b1;
               if (mem_ack) begin
                  w_cw.dr_ld   = 1'b1;
                  w_cw.seq_inc = 1'b1;
               end
            end
            N'(ADD2): begin
               w_cw.ac_ld   = 1'b1;
               w_cw.seq_clr = 1'b1;
            end
            N'(AND2): begin
               w_cw.ac_ld   = 1'b1;
               w_cw.alu_sel = 1'b1;
               w_cw.seq_clr = 1'b1;
            end
            N'(JMP1): begin
               w_cw.pc_ld   = 1'b1;
               w_cw.seq_clr = 1'b1;
            end
            N'(INC1): begin
               w_cw.ac_inc  = 1'b1;
               w_cw.seq_clr = 1'b1;
            end
            default: w_illegal = 1'b1;
         endcase
      end
   end

   assign w_wait = w_cw.mem_rd && !mem_ack;

   mem_wait_timer #(
      .TO_BITS     (TO_BITS),
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .i_wait    (w_wait),
      .o_timeout (w_timeout),
      .o_count   (wait_cnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fault <= 1'b0;
      end else if (w_timeout || w_illegal) begin
         r_fault <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_icnt <= '0;
      end else if (w_cw.seq_clr) begin
         r_icnt <= r_icnt + 1'b1;
      end
   end

   assign mem_rd      = w_cw.mem_rd;
   assign ar_ld       = w_cw.ar_ld;
   assign ar_sel      = w_cw.ar_sel;
   assign pc_ld       = w_cw.pc_ld;
   assign pc_inc      = w_cw.pc_inc;
   assign dr_ld       = w_cw.dr_ld;
   assign ir_ld       = w_cw.ir_ld;
   assign ac_ld       = w_cw.ac_ld;
   assign ac_inc      = w_cw.ac_inc;
   assign alu_sel     = w_cw.alu_sel;
   assign seq_load    = w_cw.seq_load;
   assign seq_inc     = w_cw.seq_inc;
   assign seq_clr     = w_cw.seq_clr;
   assign fault       = r_fault;
   assign instr_count = r_icnt;

endmodule
